cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception sink for the pipelined MIPS core; sits at the M stage.
- Consumes the 5-bit exception code produced and carried down the pipeline (Execute code 12 overflow, 5 store-address, 4 load-address) plus external hardware interrupts.
- Decides exception entry, drives flush/redirect to the handler, holds SR/Cause/EPC/PRId, and serves mfc0/mtc0/eret.

Parameters:
- PRID, 32'h4B4E_0001, read-only processor ID (CP0 reg 15)
- HANDLER, 32'h0000_4180, exception vector driven on ExcPC

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- PC_M  in  32  PC of instruction in M stage
- Exc_M  in  5  exception code of M-stage instruction; 0 = none
- BD_M  in  1  M-stage instruction is in a branch delay slot
- VAddr_M  in  32  memory address of M-stage load/store
- HWInt  in  6  external interrupt lines
- A1  in  5  mfc0 read register number
- A2  in  5  mtc0 write register number
- DIn  in  32  mtc0 write data
- WE  in  1  mtc0 write enable
- EXLClr  in  1  eret in M stage
- DOut  out  32  mfc0 read data (combinational)
- EPC_out  out  32  current EPC (eret target)
- IntReq  out  1  take exception/interrupt this cycle (flush all stages, redirect PC)
- ExcPC  out  32  constant HANDLER

Behaviour:
- Clock and reset: clk is the only clock; reset is asynchronous and active-high. Reset clears SR, Cause, EPC and BadVAddr to 0.
  - Outputs after reset: IntReq=0, DOut per A1 (PRId if A1=15), EPC_out=0.
- SR (reg 12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause (reg 13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits read 0.
  - IP <= HWInt every clock edge, unconditionally.
- EPC (reg 14): bits [1:0] always 0.
- PRId (reg 15): returns PRID.
- Combinational request:
  - int = |(HWInt & SR.IM) & SR.IE & !SR.EXL
  - exc = (Exc_M != 0) & !SR.EXL
  - IntReq = int | exc
  - Interrupt has priority over a synchronous exception.
- On a clock edge with IntReq=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int ? 0 : Exc_M.
  - Cause.BD <= BD_M.
  - EPC <= (BD_M ? PC_M-4 : PC_M) & ~3.
  - Latency: IntReq is valid in the same cycle; the registers update at the following edge.
- mtc0 (WE=1, IntReq=0):
  - A2=12 writes SR bits 15:10, 1 and 0.
  - A2=14 writes EPC with DIn & ~3.
  - Writes to Cause, PRId or unmapped numbers are ignored.
- Simultaneous events:
  - WE=1 with IntReq=1: the write is dropped.
  - EXLClr=1 on an edge (IntReq=0): SR.EXL <= 0. If WE also targets SR that edge, the EXL bit is still cleared after the write is applied.
- Reads:
  - DOut = register selected by A1; unmapped numbers read 0.
  - A read in the same cycle as a write returns the old value (no bypass).
- Nested entry is blocked while EXL=1:
  - Exc_M is ignored.
  - HWInt is latched in Cause.IP only.
- Reset asserted mid-handler: EXL clears immediately (asynchronous); a pending IntReq is dropped.

Optional Feature:
- Macro CP0_BADVADDR_EN.
- Defined: CP0 reg 8 BadVAddr exists.
  - On exception entry with int=0 and Exc_M = 4 or 5, BadVAddr <= VAddr_M; otherwise it holds.
  - Read-only via mfc0; reset value 0.
- Undefined: reg 8 reads 0, VAddr_M is ignored, and no register is synthesized.

Test Plan:
- Reset, then read A1=15 -> DOut=32'h4B4E_0001; A1=12/13/14 -> 0; IntReq=0.
- mtc0 SR=32'h0000_0401, HWInt=6'b000001 -> IntReq=1 same cycle. Next cycle: SR=32'h0000_0403, Cause=32'h0000_0400 (ExcCode 0, IP0=1), EPC=PC_M.
- SR.IE=1 and IM=0, Exc_M=12, PC_M=32'h0000_3010, BD_M=1 -> IntReq=1; Cause.ExcCode=12, BD=1, EPC=32'h0000_300C.
- Exc_M=5 and enabled HWInt in the same cycle -> ExcCode=0. Then, while EXL=1, Exc_M=4 -> IntReq=0 and EPC unchanged. Then EXLClr -> EXL=0 next cycle.
- WE=1, A2=14, DIn=32'h0000_3007 in the same cycle as IntReq=1 -> write dropped, EPC holds the exception PC. Without IntReq, the same write -> EPC=32'h0000_3004.
- With CP0_BADVADDR_EN: Exc_M=4, VAddr_M=32'h0000_0013 -> reg 8 reads 32'h0000_0013. Without the macro -> reg 8 reads 0.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 exception sink: SR/Cause/EPC/PRId, entry decision, mfc0/mtc0/eret (optional BadVAddr via CP0_BADVADDR_EN)
module cp0_exc_unit #(
  parameter logic [31:0] PRID    = 32'h4B4E_0001,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M,
  input  logic [4:0]  Exc_M,
  input  logic        BD_M,
  input  logic [31:0] VAddr_M,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPC_out,
  output logic        IntReq,
  output logic [31:0] ExcPC
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:2] epc;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] entry_pc;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_pend = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_pend = (Exc_M != 5'd0) & ~sr_exl;
  assign IntReq   = int_pend | exc_pend;
  assign ExcPC    = HANDLER;
  assign EPC_out  = {epc, 2'b00};

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign entry_pc = BD_M ? (PC_M - 32'd4) : PC_M;

  assign sr_val    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
  assign cause_val = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};

  // Status register: entry sets EXL; mtc0 only when no entry; eret clears EXL last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im  <= 6'd0;
      sr_exl <= 1'b0;
      sr_ie  <= 1'b0;
    end else if (IntReq) begin
      sr_exl <= 1'b1;
    end else begin
      if (WE && (A2 == REG_SR)) begin
        sr_im  <= DIn[15:10];
        sr_exl <= DIn[1];
        sr_ie  <= DIn[0];
      end
      if (EXLClr) begin
        sr_exl <= 1'b0;
      end
    end
  end

  // Cause register: IP samples the interrupt lines every edge; BD/ExcCode load on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_ip  <= 6'd0;
      cause_bd  <= 1'b0;
      cause_exc <= 5'd0;
    end else begin
      cause_ip <= HWInt;
      if (IntReq) begin
        cause_bd  <= BD_M;
        cause_exc <= int_pend ? 5'd0 : Exc_M;
      end
    end
  end

  // EPC: loaded with the restart PC on entry, else writable by mtc0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc <= 30'd0;
    end else if (IntReq) begin
      epc <= entry_pc[31:2];
    end else if (WE && (A2 == REG_EPC)) begin
      epc <= DIn[31:2];
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr;

  // BadVAddr captures the faulting address on address-error entry only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr <= 32'd0;
    end else if (IntReq && !int_pend && ((Exc_M == 5'd4) || (Exc_M == 5'd5))) begin
      badvaddr <= VAddr_M;
    end
  end
`else
  logic unused_vaddr;
  assign unused_vaddr = ^VAddr_M;
`endif

  // mfc0 read mux: registered values only, so a same-cycle write is not visible.
  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:       DOut = sr_val;
      REG_CAUSE:    DOut = cause_val;
      REG_EPC:      DOut = {epc, 2'b00};
      REG_PRID:     DOut = PRID;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: DOut = badvaddr;
`endif
      default:      DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - directed vector bench for cp0_exc_unit
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID_V = 32'h4B4E_0001;
`ifdef CP0_BADVADDR_EN
  localparam logic [31:0] BV_EXP = 32'h0000_0013;
`else
  localparam logic [31:0] BV_EXP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_M;
  logic [4:0]  Exc_M;
  logic        BD_M;
  logic [31:0] VAddr_M;
  logic [5:0]  HWInt;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPC_out;
  logic        IntReq;
  logic [31:0] ExcPC;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] pc;
    logic [5:0]  hw;
    logic        clr;
    logic [31:0] vaddr;
    logic [4:0]  a1;
    logic        e_req;
    logic [31:0] e_dout;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs[$];

  cp0_exc_unit dut (
    .clk(clk), .reset(reset), .PC_M(PC_M), .Exc_M(Exc_M), .BD_M(BD_M),
    .VAddr_M(VAddr_M), .HWInt(HWInt), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .EXLClr(EXLClr), .DOut(DOut), .EPC_out(EPC_out), .IntReq(IntReq), .ExcPC(ExcPC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [4:0] a2, input logic [31:0] din,
                     input logic [4:0] exc, input logic bd, input logic [31:0] pc,
                     input logic [5:0] hw, input logic clr, input logic [31:0] vaddr,
                     input logic [4:0] a1, input logic e_req, input logic [31:0] e_dout,
                     input logic [31:0] e_epc);
    vec_t v;
    v = '{we, a2, din, exc, bd, pc, hw, clr, vaddr, a1, e_req, e_dout, e_epc};
    vecs.push_back(v);
  endtask

  task automatic idle();
    WE = 0; A2 = 0; DIn = 0; Exc_M = 0; BD_M = 0; PC_M = 0;
    HWInt = 0; EXLClr = 0; VAddr_M = 0; A1 = 0;
  endtask

  initial begin
    //   we a2  din           exc bd pc            hw clr vaddr         a1  req dout           epc
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        15, 0, PRID_V,        32'h0);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        12, 0, 32'h0,         32'h0);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        13, 0, 32'h0,         32'h0);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        14, 0, 32'h0,         32'h0);
    add(1, 12, 32'h0000_0401, 0, 0, 32'h0,        0, 0, 32'h0,        12, 0, 32'h0,         32'h0);
    add(0, 0,  32'h0,        0,  0, 32'h0000_2000, 1, 0, 32'h0,       12, 1, 32'h0000_0401, 32'h0);
    add(0, 0,  32'h0,        0,  0, 32'h0,        1, 0, 32'h0,        12, 0, 32'h0000_0403, 32'h0000_2000);
    add(0, 0,  32'h0,        0,  0, 32'h0,        1, 0, 32'h0,        13, 0, 32'h0000_0400, 32'h0000_2000);
    add(0, 0,  32'h0,        4,  0, 32'h0000_7000, 1, 0, 32'h0,       14, 0, 32'h0000_2000, 32'h0000_2000);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 1, 32'h0,        12, 0, 32'h0000_0403, 32'h0000_2000);
    add(1, 12, 32'h0000_0001, 0, 0, 32'h0,        0, 0, 32'h0,        12, 0, 32'h0000_0401, 32'h0000_2000);
    add(0, 0,  32'h0,        12, 1, 32'h0000_3010, 0, 0, 32'h0,       12, 1, 32'h0000_0001, 32'h0000_2000);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        13, 0, 32'h8000_0030, 32'h0000_300C);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 1, 32'h0,        14, 0, 32'h0000_300C, 32'h0000_300C);
    add(1, 12, 32'h0000_0401, 0, 0, 32'h0,        0, 0, 32'h0,        12, 0, 32'h0000_0001, 32'h0000_300C);
    add(0, 0,  32'h0,        5,  0, 32'h0000_4000, 1, 0, 32'h0,       12, 1, 32'h0000_0401, 32'h0000_300C);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        13, 0, 32'h0000_0400, 32'h0000_4000);
    add(1, 12, 32'h0000_0403, 0, 0, 32'h0,        0, 1, 32'h0,        14, 0, 32'h0000_4000, 32'h0000_4000);
    add(1, 14, 32'h0000_3007, 12, 0, 32'h0000_5008, 0, 0, 32'h0,      12, 1, 32'h0000_0401, 32'h0000_4000);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 1, 32'h0,        14, 0, 32'h0000_5008, 32'h0000_5008);
    add(1, 14, 32'h0000_3007, 0, 0, 32'h0,        0, 0, 32'h0,        14, 0, 32'h0000_5008, 32'h0000_5008);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        14, 0, 32'h0000_3004, 32'h0000_3004);
    add(1, 13, 32'hFFFF_FFFF, 0, 0, 32'h0,        0, 0, 32'h0,        13, 0, 32'h0000_0030, 32'h0000_3004);
    add(1, 15, 32'h1234_5678, 0, 0, 32'h0,        0, 0, 32'h0,        13, 0, 32'h0000_0030, 32'h0000_3004);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        15, 0, PRID_V,        32'h0000_3004);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        3,  0, 32'h0,         32'h0000_3004);
    add(0, 0,  32'h0,        4,  0, 32'h0000_6000, 0, 0, 32'h0000_0013, 8, 1, 32'h0,        32'h0000_3004);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        8,  0, BV_EXP,        32'h0000_6000);
    add(0, 0,  32'h0,        0,  0, 32'h0,        0, 1, 32'h0,        12, 0, 32'h0000_0403, 32'h0000_6000);

    idle();
    reset = 1;
    A1 = 15;
    repeat (2) @(negedge clk);
    #1;
    chk("reset IntReq", {31'd0, IntReq}, 32'd0);
    chk("reset DOut prid", DOut, PRID_V);
    chk("reset EPC_out", EPC_out, 32'd0);
    chk("ExcPC", ExcPC, 32'h0000_4180);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      WE = vecs[i].we; A2 = vecs[i].a2; DIn = vecs[i].din; Exc_M = vecs[i].exc;
      BD_M = vecs[i].bd; PC_M = vecs[i].pc; HWInt = vecs[i].hw; EXLClr = vecs[i].clr;
      VAddr_M = vecs[i].vaddr; A1 = vecs[i].a1;
      #1;
      chk($sformatf("v%0d IntReq", i), {31'd0, IntReq}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d DOut", i), DOut, vecs[i].e_dout);
      chk($sformatf("v%0d EPC_out", i), EPC_out, vecs[i].e_epc);
    end

    // Pending interrupt dropped by an asynchronous reset mid-cycle.
    @(negedge clk);
    idle();
    HWInt = 6'b000001; A1 = 12;
    #1;
    chk("pend IntReq", {31'd0, IntReq}, 32'd1);
    chk("pend SR", DOut, 32'h0000_0401);
    #2 reset = 1;
    #1;
    chk("async rst IntReq", {31'd0, IntReq}, 32'd0);
    chk("async rst SR", DOut, 32'd0);
    chk("async rst EPC", EPC_out, 32'd0);
    @(negedge clk);
    reset = 0;

    // EXL set by software, then cleared by reset before any clock edge.
    @(negedge clk);
    idle();
    WE = 1; A2 = 12; DIn = 32'h0000_0402; A1 = 12;
    @(negedge clk);
    WE = 0;
    #1;
    chk("exl set SR", DOut, 32'h0000_0402);
    #2 reset = 1;
    #1;
    chk("exl async clear", DOut, 32'd0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("exl after release", DOut, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
